// File: rtl/picomem_wb_pkg.sv
// Shared encodings and constants for the PicoMem to Wishbone bridge.
package picomem_wb_pkg;

    // Bridge FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Read data returned when the slave errors or never answers
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Byte select used for every read
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/picomem_wb_bridge.sv
// PicoMem slave to Wishbone B4 classic master bridge.
// Each PicoMem request is issued as one Wishbone single cycle.
// A watchdog terminates cycles that a slave never answers.
// A sticky error flag records the address of the first failing access.
//
// Handshakes:
//   PicoMem side: the master holds mem_s_valid and the request fields until
//   mem_s_ready pulses for one cycle. mem_s_rdata is meaningful only while
//   mem_s_ready is 1 and is 0 otherwise.
//   Wishbone side: cyc/stb rise together. adr/dat/sel/we stay constant while
//   stb is high. The cycle ends on the first edge that samples ack or err, or
//   when stb has been high for TIMEOUT cycles. ack wins over err.
module picomem_wb_bridge
    import picomem_wb_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_s_valid,
    output logic              mem_s_ready,
    input  logic [31:0]       mem_s_addr,
    input  logic [31:0]       mem_s_wdata,
    input  logic [3:0]        mem_s_wstrb,
    output logic [31:0]       mem_s_rdata,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              bus_err,
    output logic [31:0]       err_addr,
    input  logic              err_clr,
    output logic [1:0]        dbg_state
);

    // The timer counts completed stalled stb cycles. Reaching TIMEOUT-1 means
    // the current cycle is the TIMEOUT-th one with stb high.
    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic                r_ready;
    logic [31:0]         r_rdata;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [ADDR_W-1:0]   r_adr;
    logic [31:0]         r_dat;
    logic [3:0]          r_sel;
    logic [31:0]         r_req_addr;
    logic                r_bus_err;
    logic [31:0]         r_err_addr;

    logic                w_is_write;
    logic                w_fail;

    assign w_is_write = |mem_s_wstrb;
    // Failure termination: slave error without ack, or watchdog expiry
    assign w_fail     = !wb_ack_i && (wb_err_i || (r_timer == TMR_LAST));

    // Bridge FSM, watchdog and sticky error report
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_req_addr <= '0;
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_ready <= 1'b0;
            r_rdata <= '0;

            // A clear is overridden below when a failure lands in the same cycle
            if (err_clr) begin
                r_bus_err  <= 1'b0;
                r_err_addr <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (mem_s_valid) begin
                        r_adr      <= mem_s_addr[ADDR_W+1:2];
                        r_dat      <= mem_s_wdata;
                        r_we       <= w_is_write;
                        r_sel      <= w_is_write ? mem_s_wstrb : WB_SEL_ALL;
                        r_req_addr <= mem_s_addr;
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wb_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_rdata <= r_we ? 32'h0 : wb_dat_i;
                        r_ready <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (w_fail) begin
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_rdata   <= r_we ? 32'h0 : ERR_RDATA;
                        r_ready   <= 1'b1;
                        r_bus_err <= 1'b1;
                        // First failure wins unless this cycle also clears
                        if (!r_bus_err || err_clr) begin
                            r_err_addr <= r_req_addr;
                        end
                        r_state   <= ST_RESP;
                    end else if (r_timer != TMR_MAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_s_ready = r_ready;
    assign mem_s_rdata = r_rdata;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_stb;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_sel_o    = r_sel;
    assign bus_err     = r_bus_err;
    assign err_addr    = r_err_addr;
    assign dbg_state   = r_state;

endmodule
